// File: rtl/fifo_rd_stream.sv
// Drains a first-word-fall-through FIFO into a valid/ready stream through a two-entry registered buffer.
// One cycle from pop to m_valid_o; the pop strobe depends only on reset, fifo_empty_i and buffer occupancy, never on m_ready_i.
module fifo_rd_stream #(
    parameter int WordLength = 8,
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  fifo_rd_o,
    input  logic [WordLength-1:0] fifo_r_data_i,
    input  logic                  fifo_empty_i,
    output logic [WordLength-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [1:0]            level_o,
    output logic [CountWidth-1:0] xfer_count_o
);

    typedef enum logic [1:0] {
        LVL_EMPTY = 2'd0,
        LVL_ONE   = 2'd1,
        LVL_TWO   = 2'd2
    } level_e;

    level_e                  level_q, level_d;
    logic [WordLength-1:0]   head_q, head_d;
    logic [WordLength-1:0]   skid_q, skid_d;
    logic [CountWidth-1:0]   xfer_count_q, xfer_count_d;
    logic                    pop;
    logic                    take;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        level_d      = level_q;
        xfer_count_d = xfer_count_q;

        // A free slot is judged from registered occupancy alone, so the pop
        // never waits on the consumer in the same cycle.
        pop  = !rst_i && !fifo_empty_i && (level_q != LVL_TWO);
        take = (level_q != LVL_EMPTY) && m_ready_i;

        case (level_q)
            LVL_EMPTY: begin
                if (pop) begin
                    head_d  = fifo_r_data_i;
                    level_d = LVL_ONE;
                end
            end
            LVL_ONE: begin
                if (pop && take) begin
                    head_d = fifo_r_data_i;
                end else if (pop) begin
                    skid_d  = fifo_r_data_i;
                    level_d = LVL_TWO;
                end else if (take) begin
                    level_d = LVL_EMPTY;
                end
            end
            LVL_TWO: begin
                if (take) begin
                    head_d  = skid_q;
                    level_d = LVL_ONE;
                end
            end
            default: begin
                level_d = LVL_EMPTY;
            end
        endcase

        if (take) begin
            xfer_count_d = xfer_count_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q      <= LVL_EMPTY;
            head_q       <= '0;
            skid_q       <= '0;
            xfer_count_q <= '0;
        end else begin
            level_q      <= level_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign fifo_rd_o    = pop;
    assign m_valid_o    = (level_q != LVL_EMPTY);
    assign m_data_o     = head_q;
    assign level_o      = level_q;
    assign xfer_count_o = xfer_count_q;

endmodule
